// File: rtl/coh_noc_pkg.sv
// Shared NoC types: virtual channels, flit container and credit sizing used by
// the link-side schedulers.
package coh_noc_pkg;

  typedef enum logic [1:0] {
    VC_REQ = 2'd0,
    VC_RSP = 2'd1,
    VC_DAT = 2'd2,
    VC_SNP = 2'd3
  } virtual_channel_e;

  localparam int CREDIT_COUNT_WIDTH = 8;
  localparam int VC_BUFFER_DEPTH    = 16;
  localparam int MAX_CREDITS        = 255;

  typedef struct packed {
    logic [10:0]  hdr;
    logic [719:0] data;
  } flit_fields_t;

  typedef union packed {
    logic [730:0] raw;
    flit_fields_t fields;
  } flit_u;

  localparam int NUM_VC = 4;
  localparam int FLIT_W = $bits(flit_u);

  typedef logic [NUM_VC-1:0] vc_mask_t;

  function automatic logic [1:0] vc_mask_to_idx(input vc_mask_t m);
    logic [1:0] idx;
    case (m)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/coh_noc_rr_arb4.sv
// Four-way rotating-priority arbiter; a held lock pins the grant to one
// requester so multi-flit packets stay contiguous.
module coh_noc_rr_arb4
  import coh_noc_pkg::*;
(
  input  vc_mask_t   req,
  input  logic [1:0] ptr,
  input  logic       lock_en,
  input  logic [1:0] lock_idx,
  output vc_mask_t   gnt
);

  logic       found_s;
  logic       hit_s;
  logic [1:0] idx_s;

  // Grant selection: locked owner only, otherwise first requester from ptr upward.
  always_comb begin
    gnt     = {NUM_VC{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 2'd0;
    if (lock_en) begin
      gnt[lock_idx] = req[lock_idx];
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        idx_s      = ptr + i[1:0];
        hit_s      = req[idx_s] & ~found_s;
        gnt[idx_s] = hit_s;
        found_s    = found_s | hit_s;
      end
    end
  end

endmodule

// File: rtl/coh_noc_vc_link_sched_chk.sv
// Protocol checks for the VC link scheduler grant vector.
module coh_noc_vc_link_sched_chk
  import coh_noc_pkg::*;
(
  input logic     clk,
  input logic     rst,
  input vc_mask_t gnt
);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: rtl/coh_noc_vc_link_sched.sv
// Credit-based scheduler multiplexing the four CHI virtual channels onto one
// physical link, one registered flit per cycle.
module coh_noc_vc_link_sched #(
  parameter int NUM_VC       = coh_noc_pkg::NUM_VC,
  parameter int FLIT_W       = coh_noc_pkg::FLIT_W,
  parameter int CNT_W        = coh_noc_pkg::CREDIT_COUNT_WIDTH,
  parameter int INIT_CREDITS = coh_noc_pkg::VC_BUFFER_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_VC-1:0]        in_valid,
  output logic [NUM_VC-1:0]        in_ready,
  input  logic [NUM_VC*FLIT_W-1:0] in_flit,
  input  logic [NUM_VC-1:0]        in_last,
  input  logic [NUM_VC-1:0]        credit_ret,
  output logic                     out_valid,
  output logic [1:0]               out_vc,
  output logic [FLIT_W-1:0]        out_flit,
  output logic [NUM_VC*CNT_W-1:0]  credit_cnt,
  output logic                     credit_err
);

  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_CREDITS);

  logic [CNT_W-1:0]      cnt_r [NUM_VC];
  coh_noc_pkg::vc_mask_t elig_s;
  coh_noc_pkg::vc_mask_t full_s;
  coh_noc_pkg::vc_mask_t gnt_s;
  logic [1:0]            gidx_s;
  logic                  any_gnt_s;
  logic                  glast_s;
  logic [FLIT_W-1:0]     gflit_s;
  logic                  lock_en_r;
  logic [1:0]            lock_vc_r;
  logic [1:0]            rr_ptr_r;
  logic                  out_valid_r;
  logic [1:0]            out_vc_r;
  logic [FLIT_W-1:0]     out_flit_r;
  logic                  credit_err_r;

  // Per-VC eligibility and saturation flags from the credit counters.
  always_comb begin
    elig_s = {NUM_VC{1'b0}};
    full_s = {NUM_VC{1'b0}};
    for (int v = 0; v < NUM_VC; v++) begin
      elig_s[v] = in_valid[v] & (cnt_r[v] != {CNT_W{1'b0}});
      full_s[v] = (cnt_r[v] == INIT_CNT);
    end
  end

  coh_noc_rr_arb4 u_arb (
    .req      (elig_s),
    .ptr      (rr_ptr_r),
    .lock_en  (lock_en_r),
    .lock_idx (lock_vc_r),
    .gnt      (gnt_s)
  );

  coh_noc_vc_link_sched_chk u_chk (
    .clk (clk),
    .rst (rst),
    .gnt (gnt_s)
  );

  // Granted VC decode and handshake; reset masks the grant toward the sources.
  always_comb begin
    gidx_s    = coh_noc_pkg::vc_mask_to_idx(gnt_s);
    any_gnt_s = |gnt_s;
    glast_s   = in_last[gidx_s];
    gflit_s   = in_flit[int'(gidx_s)*FLIT_W +: FLIT_W];
    if (rst) begin
      in_ready = {NUM_VC{1'b0}};
    end else begin
      in_ready = gnt_s;
    end
  end

  // Output register plus packet lock and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_vc_r    <= coh_noc_pkg::VC_REQ;
      out_flit_r  <= {FLIT_W{1'b0}};
      lock_en_r   <= 1'b0;
      lock_vc_r   <= coh_noc_pkg::VC_REQ;
      rr_ptr_r    <= coh_noc_pkg::VC_REQ;
    end else if (any_gnt_s) begin
      out_valid_r <= 1'b1;
      out_vc_r    <= gidx_s;
      out_flit_r  <= gflit_s;
      if (glast_s) begin
        lock_en_r <= 1'b0;
        rr_ptr_r  <= gidx_s + 2'd1;
      end else begin
        lock_en_r <= 1'b1;
        lock_vc_r <= gidx_s;
      end
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  // Credit counters: a return and a grant on one VC cancel; a return at the
  // initial level is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        cnt_r[v] <= INIT_CNT;
      end
      credit_err_r <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        case ({credit_ret[v], gnt_s[v]})
          2'b10: begin
            if (full_s[v]) begin
              cnt_r[v] <= cnt_r[v];
            end else begin
              cnt_r[v] <= cnt_r[v] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          2'b01:   cnt_r[v] <= cnt_r[v] - {{(CNT_W-1){1'b0}}, 1'b1};
          default: cnt_r[v] <= cnt_r[v];
        endcase
      end
      credit_err_r <= credit_err_r | (|(credit_ret & ~gnt_s & full_s));
    end
  end

  // Flatten the counters onto the status port.
  always_comb begin
    credit_cnt = {(NUM_VC*CNT_W){1'b0}};
    for (int v = 0; v < NUM_VC; v++) begin
      credit_cnt[v*CNT_W +: CNT_W] = cnt_r[v];
    end
  end

  assign out_valid  = out_valid_r;
  assign out_vc     = out_vc_r;
  assign out_flit   = out_flit_r;
  assign credit_err = credit_err_r;

endmodule

// File: tb/tb_coh_noc_vc_link_sched.sv
// Scoreboard bench for coh_noc_vc_link_sched: directed scenarios followed by
// random traffic, checked against a credit/lock/round-robin reference model.
module tb_coh_noc_vc_link_sched;
  import coh_noc_pkg::*;

  localparam int CW   = CREDIT_COUNT_WIDTH;
  localparam int INIT = VC_BUFFER_DEPTH;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_VC-1:0]        in_valid = '0;
  logic [NUM_VC-1:0]        in_ready;
  logic [NUM_VC*FLIT_W-1:0] in_flit = '0;
  logic [NUM_VC-1:0]        in_last = '0;
  logic [NUM_VC-1:0]        credit_ret = '0;
  logic                     out_valid;
  logic [1:0]               out_vc;
  logic [FLIT_W-1:0]        out_flit;
  logic [NUM_VC*CW-1:0]     credit_cnt;
  logic                     credit_err;

  coh_noc_vc_link_sched dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flit    (in_flit),
    .in_last    (in_last),
    .credit_ret (credit_ret),
    .out_valid  (out_valid),
    .out_vc     (out_vc),
    .out_flit   (out_flit),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [1:0]        vc;
    logic [FLIT_W-1:0] flit;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Reference model state: plain integers
  int m_cred [NUM_VC] = '{INIT, INIT, INIT, INIT};
  int m_lock = -1;
  int m_ptr  = 0;
  bit m_err  = 1'b0;
  int snap_cnt [NUM_VC] = '{INIT, INIT, INIT, INIT};
  bit snap_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, predict, check in_ready, advance model.
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [3:0] r, input logic rs);
    logic [767:0] tmp;
    logic [3:0]   exp_rdy;
    int           g;
    int           best_d;
    int           d;
    int           nc;
    exp_t         e;
    #1;
    rst        = rs;
    in_valid   = v;
    in_last    = l;
    credit_ret = r;
    for (int k = 0; k < NUM_VC; k++) begin
      for (int j = 0; j < 24; j++) tmp[j*32 +: 32] = $urandom;
      in_flit[k*FLIT_W +: FLIT_W] = tmp[FLIT_W-1:0];
    end
    g = -1;
    if (!rs) begin
      if (m_lock >= 0) begin
        if (v[m_lock] && m_cred[m_lock] > 0) g = m_lock;
      end else begin
        best_d = NUM_VC;
        for (int q = 0; q < NUM_VC; q++) begin
          d = (q - m_ptr + NUM_VC) % NUM_VC;
          if (v[q] && m_cred[q] > 0 && d < best_d) begin
            best_d = d;
            g = q;
          end
        end
      end
    end
    #1;
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", in_ready, exp_rdy);
    for (int q = 0; q < NUM_VC; q++) snap_cnt[q] = m_cred[q];
    snap_err = m_err;
    if (rs) begin
      for (int q = 0; q < NUM_VC; q++) m_cred[q] = INIT;
      m_lock = -1;
      m_ptr  = 0;
      m_err  = 1'b0;
    end else begin
      if (g >= 0) begin
        e.cyc  = cyc;
        e.vc   = 2'(g);
        e.flit = in_flit[g*FLIT_W +: FLIT_W];
        exp_q.push_back(e);
        if (l[g]) begin
          m_lock = -1;
          m_ptr  = (g + 1) % NUM_VC;
        end else begin
          m_lock = g;
        end
      end
      for (int q = 0; q < NUM_VC; q++) begin
        nc = m_cred[q] - ((g == q) ? 1 : 0) + (r[q] ? 1 : 0);
        if (nc > INIT) begin
          nc    = INIT;
          m_err = 1'b1;
        end
        m_cred[q] = nc;
      end
    end
    @(posedge clk);
  endtask

  // Monitor: compare link output and status against the scoreboard each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int v = 0; v < NUM_VC; v++)
        chk($sformatf("credit_cnt[%0d]", v), credit_cnt[v*CW +: CW], snap_cnt[v]);
      chk("credit_err", credit_err, snap_err);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
        mon_e = exp_q.pop_front();
        chk("out_valid", out_valid, 64'd1);
        chk("out_vc", out_vc, mon_e.vc);
        n_checks++;
        if (out_flit !== mon_e.flit) begin
          n_fail++;
          $display("FAIL out_flit: got %h expected %h", out_flit[127:0], mon_e.flit[127:0]);
        end
      end else begin
        chk("out_valid idle", out_valid, 64'd0);
      end
    end
  end

  initial begin
    // Reset, with all sources requesting
    step(4'hF, 4'hF, 4'h0, 1'b1);
    mon_en = 1'b1;
    step(4'hF, 4'hF, 4'h0, 1'b1);
    #3;
    for (int v = 0; v < NUM_VC; v++) chk("reset credit", credit_cnt[v*CW +: CW], 64'd16);
    chk("reset out_valid", out_valid, 64'd0);
    chk("reset credit_err", credit_err, 64'd0);

    // Fairness: REQ,RSP,DAT,SNP then REQ,RSP
    for (int i = 0; i < 4; i++) step(4'hF, 4'hF, 4'h0, 1'b0);
    #3;
    for (int v = 0; v < NUM_VC; v++) chk("fair credit", credit_cnt[v*CW +: CW], 64'd15);
    step(4'hF, 4'hF, 4'h0, 1'b0);
    step(4'hF, 4'hF, 4'h0, 1'b0);

    // DAT packet of 4 with REQ competing; DAT valid dropped on flit 2
    step(4'b0101, 4'b0001, 4'h0, 1'b0);
    step(4'b0001, 4'b0001, 4'h0, 1'b0);
    step(4'b0101, 4'b0001, 4'h0, 1'b0);
    step(4'b0101, 4'b0001, 4'h0, 1'b0);
    step(4'b0101, 4'b0101, 4'h0, 1'b0);
    step(4'b0001, 4'b0001, 4'h0, 1'b0);

    // Credit exhaustion on SNP, then a single return
    step(4'h0, 4'hF, 4'h0, 1'b1);
    for (int i = 0; i < 18; i++) step(4'b1000, 4'hF, 4'h0, 1'b0);
    step(4'b1000, 4'hF, 4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1000, 4'hF, 4'h0, 1'b0);

    // Simultaneous grant and return on RSP; return on a full REQ
    step(4'h0, 4'hF, 4'h0, 1'b1);
    step(4'b0010, 4'hF, 4'b0010, 1'b0);
    #3;
    chk("rsp net zero", credit_cnt[1*CW +: CW], 64'd16);
    chk("no err yet", credit_err, 64'd0);
    step(4'h0, 4'hF, 4'b0001, 1'b0);
    #3;
    chk("credit_err set", credit_err, 64'd1);
    chk("req saturated", credit_cnt[0 +: CW], 64'd16);
    step(4'h0, 4'hF, 4'h0, 1'b0);
    step(4'h0, 4'hF, 4'h0, 1'b0);
    #3;
    chk("credit_err sticky", credit_err, 64'd1);

    // Reset in the middle of a locked DAT packet
    step(4'b0100, 4'h0, 4'h0, 1'b0);
    step(4'b0100, 4'h0, 4'h0, 1'b0);
    step(4'hF, 4'h0, 4'h0, 1'b1);
    step(4'hF, 4'hF, 4'h0, 1'b0);
    step(4'hF, 4'hF, 4'h0, 1'b0);

    // Random traffic: sparse returns first, then denser returns
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rv;
      logic [3:0] rl;
      logic [3:0] rr;
      rv = 4'($urandom);
      rl = 4'($urandom | $urandom);
      rr = (i < 1500) ? 4'($urandom & $urandom & $urandom) : 4'($urandom & $urandom);
      step(rv, rl, rr, ($urandom_range(0, 199) == 0));
    end

    for (int i = 0; i < 3; i++) step(4'h0, 4'hF, 4'h0, 1'b0);
    #3;
    chk("scoreboard drained", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
